grf_scoreboard: RTL and testbench

- Reader-side companion to the general register file (GRF) in the pipelined CPU.
- Sits in the decode stage. It records which architectural registers have in-flight writes from issued, not-yet-written-back instructions.
- Stalls issue while any source register still has a pending write that the GRF cannot yet supply.
- Decrements pending counts as the writeback ports (the same ports that drive GRF writes) retire them.

---
 rtl/grf_scoreboard.sv | 105 ++++++++++
 tb/tb_grf_scoreboard.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// Purpose: decode-stage scoreboard tracking pending GPR writes; stalls issue on unresolved source hazards.
// Latency: stall/issue_fire are combinational (zero cycle); counters and err update on the next clk edge.
// Backpressure: stall holds issue while a source is pending beyond this cycle's writeback or the destination counter is full.
module grf_scoreboard #(
   parameter int Read_Num  = 2,
   parameter int Write_Num = 1,
   parameter int Cnt_W     = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      issue_valid,
   input  logic                      issue_wen,
   input  logic [4:0]                issue_wadd,
   input  logic [Read_Num-1:0][4:0]  Radds,
   input  logic [Write_Num-1:0]      WE,
   input  logic [Write_Num-1:0][4:0] Wadds,
   output logic                      stall,
   output logic                      issue_fire,
   output logic [31:0]               busy,
   output logic                      err
);

   // Arithmetic width wide enough for cnt + inc and for a retire count of every port.
   localparam int SW = Cnt_W + $clog2(Write_Num + 1) + 1;
   localparam logic [Cnt_W-1:0] CNT_MAX = {Cnt_W{1'b1}};

   logic [Cnt_W-1:0] cnt_q [32];
   logic [Cnt_W-1:0] cnt_d [32];
   logic             err_q;
   logic             err_d;
   logic [SW-1:0]    ret [32];
   logic             hazard;
   logic             dest_sat;

   // Count retiring writeback ports per register; $0 never retires.
   always_comb begin
      for (int r = 0; r < 32; r++) begin
         ret[r] = '0;
         for (int j = 0; j < Write_Num; j++) begin
            if (r != 0 && WE[j] && Wadds[j] == 5'(r)) begin
               ret[r] = ret[r] + SW'(1);
            end
         end
      end
   end

   // Stall decision: a source still pending after this cycle's retires, or a full destination counter.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < Read_Num; i++) begin
         // Equal count and retire means the GRF forwards the written value this cycle.
         if (Radds[i] != 5'd0 && SW'(cnt_q[Radds[i]]) > ret[Radds[i]]) begin
            hazard = 1'b1;
         end
      end
      dest_sat = issue_wen && issue_wadd != 5'd0 &&
                 cnt_q[issue_wadd] == CNT_MAX && ret[issue_wadd] == '0;
      stall      = issue_valid && (hazard || dest_sat);
      issue_fire = issue_valid && !stall && !flush;
   end

   // Next counter values: add the fired destination, subtract retires, clamp underflow to zero and flag it.
   always_comb begin
      err_d = err_q;
      for (int r = 0; r < 32; r++) begin
         logic [SW-1:0] sum;
         sum = SW'(cnt_q[r]);
         if (r != 0 && issue_fire && issue_wen && issue_wadd == 5'(r)) begin
            sum = sum + SW'(1);
         end
         if (ret[r] > sum) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else begin
            cnt_d[r] = Cnt_W'(sum - ret[r]);
         end
      end
      cnt_d[0] = '0;
   end

   // Busy view comes from registered counts only.
   always_comb begin
      busy = '0;
      for (int r = 1; r < 32; r++) begin
         busy[r] = (cnt_q[r] != '0);
      end
   end

   assign err = err_q;

   // State update: reset beats flush; flush drops all pending writes and this cycle's writebacks, keeping err.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
         err_q <= 1'b0;
      end else if (flush) begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      end else begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_grf_scoreboard.sv
module tb_grf_scoreboard;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            flush = 1'b0;
   logic            issue_valid = 1'b0;
   logic            issue_wen = 1'b0;
   logic [4:0]      issue_wadd = '0;
   logic [1:0][4:0] Radds = '0;
   logic [0:0]      WE = '0;
   logic [0:0][4:0] Wadds = '0;
   logic            stall;
   logic            issue_fire;
   logic [31:0]     busy;
   logic            err;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: per-register pending-write counts and a sticky error bit.
   int mcnt [32];
   bit merr;

   grf_scoreboard #(.Read_Num(2), .Write_Num(1), .Cnt_W(2)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_wadd(issue_wadd),
      .Radds(Radds), .WE(WE), .Wadds(Wadds),
      .stall(stall), .issue_fire(issue_fire), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int retires(input int r);
      return (r != 0 && WE[0] && Wadds[0] == 5'(r)) ? 1 : 0;
   endfunction

   function automatic bit m_stall();
      bit h;
      h = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (Radds[i] != 0 && mcnt[Radds[i]] > retires(int'(Radds[i]))) h = 1'b1;
      end
      if (issue_wen && issue_wadd != 0 && mcnt[issue_wadd] == 3 && retires(int'(issue_wadd)) == 0) h = 1'b1;
      return issue_valid && h;
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b;
      b = '0;
      for (int r = 1; r < 32; r++) b[r] = (mcnt[r] != 0);
      return b;
   endfunction

   // Model state advances on each rising edge from the inputs held across that edge.
   always @(posedge clk) begin
      bit fire;
      fire = issue_valid && !m_stall() && !flush;
      if (reset || flush) begin
         for (int r = 0; r < 32; r++) mcnt[r] = 0;
         if (reset) merr = 1'b0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            int n;
            n = mcnt[r] + ((fire && issue_wen && issue_wadd == 5'(r)) ? 1 : 0) - retires(r);
            if (n < 0) begin
               n = 0;
               merr = 1'b1;
            end
            mcnt[r] = n;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         chk("cyc_stall", 32'(stall), 32'(m_stall()));
         chk("cyc_fire", 32'(issue_fire), 32'(issue_valid && !m_stall() && !flush));
         chk("cyc_busy", busy, m_busy());
         chk("cyc_err", 32'(err), 32'(merr));
      end
   end

   task automatic drive(input bit v, input bit wen, input int wa, input int r0, input int r1,
                        input bit we, input int wba, input bit fl);
      @(posedge clk);
      #1;
      issue_valid = v;
      issue_wen   = wen;
      issue_wadd  = 5'(wa);
      Radds[0]    = 5'(r0);
      Radds[1]    = 5'(r1);
      WE[0]       = we;
      Wadds[0]    = 5'(wba);
      flush       = fl;
      #2;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Clean issue after reset.
      drive(1, 0, 0, 5, 6, 0, 0, 0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_fire", 32'(issue_fire), 32'd1);
      chk("rst_busy", busy, 32'd0);
      chk("rst_err", 32'(err), 32'd0);

      // RAW hazard on $8 resolved by same-cycle writeback.
      drive(1, 1, 8, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 8, 0, 0, 0, 0);
      chk("raw_busy8", busy, 32'h0000_0100);
      chk("raw_stall", 32'(stall), 32'd1);
      chk("raw_fire", 32'(issue_fire), 32'd0);
      drive(1, 0, 0, 8, 0, 1, 8, 0);
      chk("fwd_stall", 32'(stall), 32'd0);
      chk("fwd_fire", 32'(issue_fire), 32'd1);
      idle();
      chk("fwd_busy", busy, 32'd0);

      // Saturation of $3 at three pending writes.
      repeat (3) drive(1, 1, 3, 0, 0, 0, 0, 0);
      drive(1, 1, 3, 0, 0, 0, 0, 0);
      chk("sat_stall", 32'(stall), 32'd1);
      chk("sat_fire", 32'(issue_fire), 32'd0);
      chk("sat_model", 32'(mcnt[3]), 32'd3);
      drive(1, 1, 3, 0, 0, 1, 3, 0);
      chk("sat_ret_stall", 32'(stall), 32'd0);
      chk("sat_ret_fire", 32'(issue_fire), 32'd1);
      idle();
      chk("sat_hold_model", 32'(mcnt[3]), 32'd3);
      chk("sat_busy3", busy, 32'h0000_0008);
      repeat (2) drive(0, 0, 0, 0, 0, 1, 3, 0);
      chk("sat_drain_busy", busy, 32'h0000_0008);
      drive(0, 0, 0, 0, 0, 1, 3, 0);
      idle();
      chk("sat_empty_busy", busy, 32'd0);
      chk("sat_empty_err", 32'(err), 32'd0);

      // Same-cycle issue and retire on $9 keeps count at one.
      drive(1, 1, 9, 0, 0, 0, 0, 0);
      drive(1, 1, 9, 0, 0, 1, 9, 0);
      chk("net_fire", 32'(issue_fire), 32'd1);
      idle();
      chk("net_busy9", busy, 32'h0000_0200);
      chk("net_model", 32'(mcnt[9]), 32'd1);
      drive(0, 0, 0, 0, 0, 1, 9, 0);
      idle();
      chk("net_clear", busy, 32'd0);

      // Underflow error, stickiness, reset clear, $0 writeback harmless.
      drive(0, 0, 0, 0, 0, 1, 12, 0);
      idle();
      chk("uf_err", 32'(err), 32'd1);
      idle();
      chk("uf_sticky", 32'(err), 32'd1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      #2 chk("uf_reset", 32'(err), 32'd0);
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      idle();
      chk("wb0_err", 32'(err), 32'd0);

      // Flush with issue and writeback in flight.
      drive(1, 1, 4, 0, 0, 0, 0, 0);
      drive(1, 1, 7, 0, 0, 0, 0, 0);
      drive(1, 1, 10, 0, 0, 1, 4, 1);
      chk("fl_busy_pre", busy, 32'h0000_0090);
      chk("fl_fire", 32'(issue_fire), 32'd0);
      idle();
      chk("fl_busy", busy, 32'd0);
      chk("fl_err", 32'(err), 32'd0);

      idle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
